// File: rtl/ysyx_23060203_divider.sv
// Iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU.
// Resolves one quotient bit per cycle. Divide-by-zero and signed overflow
// skip the iteration and complete the cycle after accept.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE and out_valid only in DONE, so the
// two are never high together. A same-cycle flush voids either transfer.
module ysyx_23060203_divider #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic              quo_neg_q, quo_neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic [XLEN-1:0]   dvsr_q, dvsr_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Request decode: op[0]=1 means unsigned, op[1]=1 selects remainder.
  logic            is_signed, a_neg, b_neg, div_zero, overflow, accept;
  // One restoring-division step on the {rem, quo} pair.
  logic [XLEN:0]   rem_sh, diff;
  logic            ge, last;
  logic [XLEN-1:0] rem_step, quo_step, q_fix, r_fix;

  // Operand classification and the shift/subtract step.
  always_comb begin
    is_signed = ~op[0];
    a_neg     = is_signed & dividend[XLEN-1];
    b_neg     = is_signed & divisor[XLEN-1];
    div_zero  = (divisor == '0);
    overflow  = is_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}})
                && (divisor == '1);
    accept    = in_valid & in_ready & ~flush;
    // rem < divisor always holds, so the shifted remainder needs one extra bit;
    // the top bit of the difference is the borrow and says "rem < divisor".
    rem_sh    = {rem_q, quo_q[XLEN-1]};
    diff      = rem_sh - {1'b0, dvsr_q};
    ge        = ~diff[XLEN];
    rem_step  = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_step  = {quo_q[XLEN-2:0], ge};
    q_fix     = quo_neg_q ? -quo_step : quo_step;
    r_fix     = rem_neg_q ? -rem_step : rem_step;
    last      = (cnt_q == CNT_W'(XLEN - 1));
  end

  // State and datapath registers; reset has priority over everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      dvsr_q    <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      dvsr_q    <= dvsr_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state logic; flush overrides any handshake in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (div_zero || overflow) ? S_DONE : S_CALC;
      S_CALC: if (last) state_d = S_DONE;
      S_DONE: if (out_valid && out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Outputs and datapath updates per state.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    result    = result_q;
    op_d      = op_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    dvsr_d    = dvsr_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d      = op;
          quo_neg_d = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          dvsr_d    = b_neg ? -divisor : divisor;
          // |dividend| sits in the quotient register and shifts into rem.
          quo_d     = a_neg ? -dividend : dividend;
          rem_d     = '0;
          cnt_d     = '0;
          if (div_zero)
            result_d = op[1] ? dividend : '1;
          else if (overflow)
            result_d = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
      end
      S_CALC: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (last) result_d = op_q[1] ? r_fix : q_fix;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060203_divider.sv
// Testbench for ysyx_23060203_divider: vector table, random ops against a
// behavioural model, and hand sequences for backpressure, flush and reset.
module tb_ysyx_23060203_divider;

  localparam int XLEN = 32;
  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01,
                         OP_REM = 2'b10, OP_REMU = 2'b11;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [1:0]      op = '0;
  logic [XLEN-1:0] dividend = '0;
  logic [XLEN-1:0] divisor = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] result;

  ysyx_23060203_divider #(.XLEN(XLEN)) dut (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result)
  );

  // Clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  logic [XLEN-1:0] exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Driver: wait for in_ready (bounded), present one request for one edge,
  // then scramble the operand inputs so late sampling would show up.
  task automatic start_op(input logic [1:0] o, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b);
    int w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clock); #1; w++;
    end
    check("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; op = o; dividend = a; divisor = b;
    @(posedge clock); #1;
    in_valid = 1'b0; op = 2'($urandom); dividend = $urandom; divisor = $urandom;
  endtask

  // Full transaction: issue, wait for result, optionally hold backpressure,
  // then consume and compare against the scoreboard entry.
  task automatic run_op(input string name, input logic [1:0] o,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] exp, input bit special,
                        input int hold);
    int lat;
    bit ir_high;
    logic [XLEN-1:0] held;
    start_op(o, a, b);
    exp_q.push_back(exp);
    lat = 1;
    ir_high = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) ir_high = 1'b1;
      @(posedge clock); #1; lat++;
    end
    check({name, "_latency"}, lat, special ? 32'd1 : 32'(XLEN + 1));
    check({name, "_in_ready_busy"}, {31'd0, ir_high | in_ready}, 32'd0);
    held = result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      check({name, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({name, "_hold_result"}, result, held);
    end
    out_ready = 1'b1;
    check(name, result, exp_q.pop_front());
    @(posedge clock); #1;
    out_ready = 1'b0;
    check({name, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
    check({name, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  typedef struct {
    string           name;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] exp;
    bit              special;
  } vec_t;

  vec_t vecs[20];

  initial begin
    vecs[0]  = '{"divu_100_7",    OP_DIVU, 32'd100,       32'd7,         32'd14,        1'b0};
    vecs[1]  = '{"remu_100_7",    OP_REMU, 32'd100,       32'd7,         32'd2,         1'b0};
    vecs[2]  = '{"div_m7_2",      OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{"rem_m7_2",      OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0};
    vecs[4]  = '{"rem_7_m2",      OP_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         1'b0};
    vecs[5]  = '{"div_7_m2",      OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0};
    vecs[6]  = '{"div_5_0",       OP_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1};
    vecs[7]  = '{"rem_5_0",       OP_REM,  32'd5,         32'd0,         32'd5,         1'b1};
    vecs[8]  = '{"divu_5_0",      OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1};
    vecs[9]  = '{"remu_ffff_0",   OP_REMU, 32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, 1'b1};
    vecs[10] = '{"div_ovf",       OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[11] = '{"rem_ovf",       OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1};
    vecs[12] = '{"divu_ovf_ops",  OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0};
    vecs[13] = '{"remu_ovf_ops",  OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0};
    vecs[14] = '{"divu_max_1",    OP_DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 1'b0};
    vecs[15] = '{"div_m100_m7",   OP_DIV,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        1'b0};
    vecs[16] = '{"rem_m100_m7",   OP_REM,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0};
    vecs[17] = '{"div_min_2",     OP_DIV,  32'h8000_0000, 32'd2,         32'hC000_0000, 1'b0};
    vecs[18] = '{"div_min_3",     OP_DIV,  32'h8000_0000, 32'd3,         32'hD555_5556, 1'b0};
    vecs[19] = '{"rem_min_3",     OP_REM,  32'h8000_0000, 32'd3,         32'hFFFF_FFFE, 1'b0};
  end

  // Main sequence
  initial begin
    logic [XLEN-1:0] ra, rb, rexp;
    logic [1:0]      rop;
    int              sa, sb;

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_result", result, 32'd0);

    // Vector table
    for (int i = 0; i < 20; i++)
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
             vecs[i].special, 0);

    // Backpressure: 10 cycles of out_ready=0 in DONE
    run_op("divu_100_7_hold", OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 10);
    run_op("rem_ovf_hold", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, 3);

    // Random operations against a behavioural model
    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      if (rb == 0) rb = 32'd1;
      if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
      sa = ra;
      sb = rb;
      case (rop)
        OP_DIV:  rexp = 32'(sa / sb);
        OP_DIVU: rexp = ra / rb;
        OP_REM:  rexp = 32'(sa % sb);
        default: rexp = ra % rb;
      endcase
      run_op("random", rop, ra, rb, rexp, 1'b0, i % 2);
    end

    // Flush at CALC cycle 10
    start_op(OP_DIVU, 32'd1000, 32'd3);
    repeat (9) begin @(posedge clock); #1; end
    check("flush_pre_busy", {31'd0, in_ready}, 32'd0);
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    check("flush_calc_in_ready", {31'd0, in_ready}, 32'd1);
    check("flush_calc_out_valid", {31'd0, out_valid}, 32'd0);

    // Flush beats a same-cycle request in IDLE
    in_valid = 1'b1; flush = 1'b1; op = OP_DIVU; dividend = 32'd8; divisor = 32'd2;
    @(posedge clock); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_not_accepted", {31'd0, in_ready}, 32'd1);
    check("flush_idle_out_valid", {31'd0, out_valid}, 32'd0);

    // Flush in DONE without a consumer drops the result
    start_op(OP_DIV, 32'd5, 32'd0);
    check("flush_done_pre_valid", {31'd0, out_valid}, 32'd1);
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    check("flush_done_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_done_in_ready", {31'd0, in_ready}, 32'd1);

    // Reset at CALC cycle 5 of a new op
    start_op(OP_DIV, 32'hFFFF_FFCE, 32'd7);
    repeat (4) begin @(posedge clock); #1; end
    reset = 1'b1; flush = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; flush = 1'b0;
    check("midreset_in_ready", {31'd0, in_ready}, 32'd1);
    check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    check("midreset_result", result, 32'd0);

    run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 1'b0, 0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
